// File: rtl/k_means_pkg.sv
// Shared definitions for the k-means host register file: register map,
// status bit positions and the run-control state type.
package k_means_pkg;

    typedef enum logic [7:0] {
        internal_status_reg = 8'd0,
        go_reg              = 8'd1,
        cent_1_reg          = 8'd2,
        cent_2_reg          = 8'd3,
        cent_3_reg          = 8'd4,
        cent_4_reg          = 8'd5,
        cent_5_reg          = 8'd6,
        cent_6_reg          = 8'd7,
        cent_7_reg          = 8'd8,
        cent_8_reg          = 8'd9,
        ram_addr_reg        = 8'd10,
        ram_data_reg        = 8'd11,
        first_ram_addr_reg  = 8'd12,
        last_ram_addr_reg   = 8'd13,
        threshold_reg       = 8'd14
    } reg_idx_e;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic is_cent_idx(input logic [7:0] idx);
        return (idx >= cent_1_reg) && (idx <= cent_8_reg);
    endfunction

endpackage

// File: rtl/k_means_regfile.sv
// Host register file in front of the k-means core (RAM load, centroids, run control, irq).
// Optional macro RAM_ADDR_AUTOINC_EN: RAM_addr post-increments on every accepted RAM_data write.
module k_means_regfile
    import k_means_pkg::*;
#(
    parameter int addrWidth       = 9,
    parameter int dataWidth       = 91,
    parameter int manhatten_width = 16,
    parameter int reg_amount      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       host_wr,
    input  logic                       host_rd,
    input  logic [reg_amount-1:0]      host_reg,
    input  logic [dataWidth-1:0]       host_wdata,
    output logic [dataWidth-1:0]       host_rdata,
    output logic                       host_rvalid,
    output logic                       host_err,
    output logic                       irq,
    output logic                       go_core,
    output logic [addrWidth-1:0]       adress2core,
    output logic [dataWidth-1:0]       data2core,
    output logic                       W_R_RAM_N,
    output logic                       CHIP_SEL_RAM_N,
    output logic [addrWidth-1:0]       first_ram_address,
    output logic [addrWidth-1:0]       last_ram_address,
    output logic [manhatten_width-1:0] threshold_value,
    input  logic                       reg_w_r,
    input  logic [reg_amount-1:0]      reg_num,
    input  logic [dataWidth-1:0]       Reg_write_data_from_core,
    input  logic                       interupt
);

    localparam logic [addrWidth-1:0] ADDR_ONE = {{(addrWidth-1){1'b0}}, 1'b1};

    state_e                     state_r;
    logic                       go_core_r;
    logic                       done_r;
    logic                       err_r;
    logic                       host_err_r;
    logic                       host_rvalid_r;
    logic [dataWidth-1:0]       host_rdata_r;
    logic [dataWidth-1:0]       cent_r [8];
    logic [addrWidth-1:0]       ram_addr_r;
    logic [dataWidth-1:0]       ram_data_r;
    logic [addrWidth-1:0]       first_r;
    logic [addrWidth-1:0]       last_r;
    logic [manhatten_width-1:0] thr_r;
    logic [addrWidth-1:0]       adress_r;
    logic                       w_r_n_r;
    logic                       cs_n_r;

    logic                       core_cent_s;
    logic                       collide_s;
    logic                       wr_ok_s;
    logic                       err_s;
    logic                       stat_wr_s;
    logic                       go_start_s;
    logic                       ram_wr_s;
    logic [2:0]                 host_cent_s;
    logic [2:0]                 core_cent_idx_s;
    logic [dataWidth-1:0]       rd_mux_s;

    // Host access decode: a host write colliding with a core centroid write loses silently.
    always_comb begin
        core_cent_s     = reg_w_r && is_cent_idx(reg_num);
        collide_s       = host_wr && core_cent_s && (host_reg == reg_num);
        host_cent_s     = 3'(host_reg - cent_1_reg);
        core_cent_idx_s = 3'(reg_num - cent_1_reg);
        wr_ok_s         = 1'b0;
        err_s           = 1'b0;
        if (host_wr) begin
            if (host_reg == internal_status_reg) begin
                wr_ok_s = 1'b1;
            end else if (host_reg > threshold_reg) begin
                wr_ok_s = 1'b0;
            end else if (collide_s) begin
                wr_ok_s = 1'b0;
            end else if (state_r == BUSY) begin
                err_s = 1'b1;
            end else begin
                wr_ok_s = 1'b1;
            end
        end else begin
            wr_ok_s = 1'b0;
        end
        if (host_wr && host_rd) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end
        stat_wr_s  = wr_ok_s && (host_reg == internal_status_reg);
        go_start_s = wr_ok_s && (host_reg == go_reg) && host_wdata[0] && (state_r == IDLE);
        ram_wr_s   = wr_ok_s && (host_reg == ram_data_reg);
    end

    // Read multiplexer over the host-visible register map.
    always_comb begin
        rd_mux_s = '0;
        case (host_reg)
            internal_status_reg: begin
                rd_mux_s[STAT_BUSY_BIT] = go_core_r;
                rd_mux_s[STAT_DONE_BIT] = done_r;
                rd_mux_s[STAT_ERR_BIT]  = err_r;
            end
            go_reg:              rd_mux_s[0] = go_core_r;
            cent_1_reg, cent_2_reg, cent_3_reg, cent_4_reg,
            cent_5_reg, cent_6_reg, cent_7_reg, cent_8_reg:
                                 rd_mux_s = cent_r[host_cent_s];
            ram_addr_reg:        rd_mux_s[addrWidth-1:0] = ram_addr_r;
            ram_data_reg:        rd_mux_s = ram_data_r;
            first_ram_addr_reg:  rd_mux_s[addrWidth-1:0] = first_r;
            last_ram_addr_reg:   rd_mux_s[addrWidth-1:0] = last_r;
            threshold_reg:       rd_mux_s[manhatten_width-1:0] = thr_r;
            default:             rd_mux_s = '0;
        endcase
    end

    // Run-control FSM; a completion pulse outranks a same-cycle W1C of done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            go_core_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go_start_s) begin
                        state_r   <= BUSY;
                        go_core_r <= 1'b1;
                    end
                end
                BUSY: begin
                    if (interupt) begin
                        state_r   <= IDLE;
                        go_core_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    go_core_r <= 1'b0;
                end
            endcase
            if ((state_r == BUSY) && interupt) begin
                done_r <= 1'b1;
            end else if (stat_wr_s && host_wdata[STAT_DONE_BIT]) begin
                done_r <= 1'b0;
            end
        end
    end

    // Sticky error flag and the one-cycle rejection pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r      <= 1'b0;
            host_err_r <= 1'b0;
        end else begin
            host_err_r <= err_s;
            if (err_s) begin
                err_r <= 1'b1;
            end else if (stat_wr_s && host_wdata[STAT_ERR_BIT]) begin
                err_r <= 1'b0;
            end
        end
    end

    // Configuration and centroid registers; the load address is latched with each RAM write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cent_r[i] <= '0;
            end
            ram_addr_r <= '0;
            ram_data_r <= '0;
            first_r    <= '0;
            last_r     <= '0;
            thr_r      <= '0;
            adress_r   <= '0;
        end else begin
            if (core_cent_s) begin
                cent_r[core_cent_idx_s] <= Reg_write_data_from_core;
            end
            if (wr_ok_s && is_cent_idx(host_reg)) begin
                cent_r[host_cent_s] <= host_wdata;
            end
            if (ram_wr_s) begin
                ram_data_r <= host_wdata;
                adress_r   <= ram_addr_r;
`ifdef RAM_ADDR_AUTOINC_EN
                ram_addr_r <= ram_addr_r + ADDR_ONE;
`endif
            end
            if (wr_ok_s && (host_reg == ram_addr_reg)) begin
                ram_addr_r <= host_wdata[addrWidth-1:0];
            end
            if (wr_ok_s && (host_reg == first_ram_addr_reg)) begin
                first_r <= host_wdata[addrWidth-1:0];
            end
            if (wr_ok_s && (host_reg == last_ram_addr_reg)) begin
                last_r <= host_wdata[addrWidth-1:0];
            end
            if (wr_ok_s && (host_reg == threshold_reg)) begin
                thr_r <= host_wdata[manhatten_width-1:0];
            end
        end
    end

    // Single-cycle active-low RAM strobe following each accepted RAM_data write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_r  <= 1'b1;
            w_r_n_r <= 1'b1;
        end else begin
            cs_n_r  <= !ram_wr_s;
            w_r_n_r <= !ram_wr_s;
        end
    end

    // Registered read response; a read paired with a write is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= '0;
        end else begin
            host_rvalid_r <= host_rd && !host_wr;
            if (host_rd && !host_wr) begin
                host_rdata_r <= rd_mux_s;
            end
        end
    end

    assign host_rdata        = host_rdata_r;
    assign host_rvalid       = host_rvalid_r;
    assign host_err          = host_err_r;
    assign irq               = done_r;
    assign go_core           = go_core_r;
    assign adress2core       = adress_r;
    assign data2core         = ram_data_r;
    assign W_R_RAM_N         = w_r_n_r;
    assign CHIP_SEL_RAM_N    = cs_n_r;
    assign first_ram_address = first_r;
    assign last_ram_address  = last_r;
    assign threshold_value   = thr_r;

endmodule

// File: tb/tb_k_means_regfile.sv
// Scoreboard bench for k_means_regfile: a behavioural register-map model predicts
// per-cycle outputs, a separate monitor compares them against the DUT.
module tb_k_means_regfile;

    logic        clk;
    logic        rst_n;
    logic        host_wr;
    logic        host_rd;
    logic [7:0]  host_reg;
    logic [90:0] host_wdata;
    logic [90:0] host_rdata;
    logic        host_rvalid;
    logic        host_err;
    logic        irq;
    logic        go_core;
    logic [8:0]  adress2core;
    logic [90:0] data2core;
    logic        W_R_RAM_N;
    logic        CHIP_SEL_RAM_N;
    logic [8:0]  first_ram_address;
    logic [8:0]  last_ram_address;
    logic [15:0] threshold_value;
    logic        reg_w_r;
    logic [7:0]  reg_num;
    logic [90:0] Reg_write_data_from_core;
    logic        interupt;

    k_means_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .host_wr(host_wr), .host_rd(host_rd), .host_reg(host_reg), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_err(host_err),
        .irq(irq), .go_core(go_core), .adress2core(adress2core), .data2core(data2core),
        .W_R_RAM_N(W_R_RAM_N), .CHIP_SEL_RAM_N(CHIP_SEL_RAM_N),
        .first_ram_address(first_ram_address), .last_ram_address(last_ram_address),
        .threshold_value(threshold_value),
        .reg_w_r(reg_w_r), .reg_num(reg_num),
        .Reg_write_data_from_core(Reg_write_data_from_core), .interupt(interupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rvalid;
        logic [90:0] rdata;
        logic        err;
        logic        pulse;
        logic [8:0]  addr;
        logic [90:0] data;
        logic        go;
        logic        irq;
        logic [8:0]  first;
        logic [8:0]  last;
        logic [15:0] thr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: what the host should observe
    logic        m_busy, m_done, m_err;
    logic [90:0] m_cent [8];
    logic [8:0]  m_addr, m_first, m_last;
    logic [90:0] m_data;
    logic [15:0] m_thr;

    task automatic chk(input string name, input logic [90:0] act, input logic [90:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [90:0] rnd91();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[90:0];
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 8; i++) m_cent[i] = '0;
        m_addr = '0; m_first = '0; m_last = '0; m_data = '0; m_thr = '0;
    endtask

    function automatic logic [90:0] m_read(input logic [7:0] r);
        logic [90:0] v;
        v = '0;
        if (r == 8'd0)                     v = 91'({m_err, m_done, m_busy});
        else if (r == 8'd1)                v = 91'(m_busy);
        else if (r >= 8'd2 && r <= 8'd9)   v = m_cent[3'(r - 8'd2)];
        else if (r == 8'd10)               v = 91'(m_addr);
        else if (r == 8'd11)               v = m_data;
        else if (r == 8'd12)               v = 91'(m_first);
        else if (r == 8'd13)               v = 91'(m_last);
        else if (r == 8'd14)               v = 91'(m_thr);
        else                               v = '0;
        return v;
    endfunction

    task automatic model_step(input logic wr, input logic rd, input logic [7:0] r,
                              input logic [90:0] wd, input logic cw, input logic [7:0] cn,
                              input logic [90:0] cd, input logic it);
        exp_t e;
        logic acc, er, cvalid, old_busy;
        old_busy = m_busy;
        e.rvalid = rd && !wr;
        e.rdata  = m_read(r);
        cvalid   = cw && (cn >= 8'd2) && (cn <= 8'd9);
        acc = 1'b0;
        er  = 1'b0;
        if (wr) begin
            if (r == 8'd0)                    acc = 1'b1;
            else if (r > 8'd14)               acc = 1'b0;
            else if (cvalid && (cn == r))     acc = 1'b0;
            else if (old_busy)                er  = 1'b1;
            else                              acc = 1'b1;
        end
        if (wr && rd) er = 1'b1;
        e.pulse = acc && (r == 8'd11);
        e.addr  = m_addr;
        if (cvalid) m_cent[3'(cn - 8'd2)] = cd;
        if (acc) begin
            if (r == 8'd0) begin
                if (wd[1]) m_done = 1'b0;
                if (wd[2]) m_err  = 1'b0;
            end
            if (r == 8'd1 && wd[0])            m_busy = 1'b1;
            if (r >= 8'd2 && r <= 8'd9)        m_cent[3'(r - 8'd2)] = wd;
            if (r == 8'd10)                    m_addr = wd[8:0];
            if (r == 8'd11) begin
                m_data = wd;
`ifdef RAM_ADDR_AUTOINC_EN
                m_addr = (m_addr == 9'd511) ? 9'd0 : m_addr + 9'd1;
`endif
            end
            if (r == 8'd12)                    m_first = wd[8:0];
            if (r == 8'd13)                    m_last  = wd[8:0];
            if (r == 8'd14)                    m_thr   = wd[15:0];
        end
        if (old_busy && it) begin
            m_busy = 1'b0;
            m_done = 1'b1;
        end
        if (er) m_err = 1'b1;
        e.err   = er;
        e.data  = m_data;
        e.go    = m_busy;
        e.irq   = m_done;
        e.first = m_first;
        e.last  = m_last;
        e.thr   = m_thr;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic wr, input logic rd, input logic [7:0] r,
                         input logic [90:0] wd, input logic cw, input logic [7:0] cn,
                         input logic [90:0] cd, input logic it);
        @(negedge clk);
        host_wr = wr; host_rd = rd; host_reg = r; host_wdata = wd;
        reg_w_r = cw; reg_num = cn; Reg_write_data_from_core = cd; interupt = it;
        model_step(wr, rd, r, wd, cw, cn, cd, it);
    endtask

    task automatic hw(input logic [7:0] r, input logic [90:0] wd);
        cycle(1'b1, 1'b0, r, wd, 1'b0, 8'd0, 91'd0, 1'b0);
    endtask

    task automatic hr(input logic [7:0] r);
        cycle(1'b0, 1'b1, r, 91'd0, 1'b0, 8'd0, 91'd0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'd0, 91'd0, 1'b0, 8'd0, 91'd0, 1'b0);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per driven cycle, compared just after the sampling edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rvalid", 91'(host_rvalid), 91'(e.rvalid));
                if (e.rvalid) chk("rdata", host_rdata, e.rdata);
                chk("host_err", 91'(host_err), 91'(e.err));
                chk("chip_sel_n", 91'(CHIP_SEL_RAM_N), 91'(!e.pulse));
                chk("w_r_n", 91'(W_R_RAM_N), 91'(!e.pulse));
                if (e.pulse) chk("adress2core", 91'(adress2core), 91'(e.addr));
                chk("data2core", data2core, e.data);
                chk("go_core", 91'(go_core), 91'(e.go));
                chk("irq", 91'(irq), 91'(e.irq));
                chk("first_addr", 91'(first_ram_address), 91'(e.first));
                chk("last_addr", 91'(last_ram_address), 91'(e.last));
                chk("threshold", 91'(threshold_value), 91'(e.thr));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        host_wr = 1'b0; host_rd = 1'b0; host_reg = '0; host_wdata = '0;
        reg_w_r = 1'b0; reg_num = '0; Reg_write_data_from_core = '0; interupt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_go_core", 91'(go_core), 91'd0);
        chk("rst_irq", 91'(irq), 91'd0);
        chk("rst_chip_sel_n", 91'(CHIP_SEL_RAM_N), 91'd1);
        chk("rst_w_r_n", 91'(W_R_RAM_N), 91'd1);
        chk("rst_rvalid", 91'(host_rvalid), 91'd0);
        chk("rst_data2core", data2core, 91'd0);
        rst_n = 1'b1;

        // RAM load
        hw(8'd10, 91'd5);
        hw(8'd11, 91'h1234);
        idle(); idle();
        // Run and completion, then W1C of done
        hw(8'd1, 91'd1);
        idle();
        cycle(1'b0, 1'b0, 8'd0, 91'd0, 1'b0, 8'd0, 91'd0, 1'b1);
        hr(8'd0);
        hw(8'd0, 91'd2);
        hr(8'd0);
        // Dropped write while busy, then completion racing a done clear
        hw(8'd1, 91'd1);
        hw(8'd4, 91'd7);
        hr(8'd4);
        hr(8'd0);
        cycle(1'b1, 1'b0, 8'd0, 91'd2, 1'b0, 8'd0, 91'd0, 1'b1);
        hr(8'd0);
        hw(8'd0, 91'd6);
        // Host/core collision on cent_1, read vs core write, wr+rd together
        cycle(1'b1, 1'b0, 8'd2, 91'hA, 1'b1, 8'd2, 91'hB, 1'b0);
        hr(8'd2);
        cycle(1'b0, 1'b1, 8'd3, 91'd0, 1'b1, 8'd3, 91'h55, 1'b0);
        hr(8'd3);
        cycle(1'b1, 1'b1, 8'd12, 91'd77, 1'b0, 8'd0, 91'd0, 1'b0);
        hr(8'd12);
        hw(8'd13, 91'd300);
        hw(8'd14, 91'hFFFF_ABCD);
        hr(8'd14);
        hw(8'd20, 91'd9);
        hr(8'd20);
        hr(8'd15);
        // Address wrap with back-to-back loads
        hw(8'd10, 91'd511);
        hw(8'd11, 91'h111);
        hw(8'd11, 91'h222);
        hr(8'd10);
        idle();

        for (int i = 0; i < 1500; i++) begin
            logic wr, rd, cw, it;
            logic [7:0] r, cn;
            logic [90:0] wd, cd;
            wr = ($urandom_range(0, 99) < 40);
            rd = ($urandom_range(0, 99) < 35);
            r  = 8'($urandom_range(0, 16));
            wd = rnd91();
            if (r == 8'd0) wd = 91'($urandom_range(0, 7));
            cw = ($urandom_range(0, 99) < 20);
            cn = 8'($urandom_range(0, 11));
            cd = rnd91();
            it = ($urandom_range(0, 99) < 6);
            cycle(wr, rd, r, wd, cw, cn, cd, it);
        end
        idle(); idle();
        drain();

        // Reset in the middle of a run
        hw(8'd0, 91'd6);
        hw(8'd1, 91'd1);
        hw(8'd5, 91'h77);
        idle();
        drain();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_go_core", 91'(go_core), 91'd0);
        chk("async_irq", 91'(irq), 91'd0);
        chk("async_chip_sel_n", 91'(CHIP_SEL_RAM_N), 91'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 16; r++) hr(8'(r));
        idle();
        drain();

        chk("queue_empty", 91'(exp_q.size()), 91'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
